// File: rtl/apb_mem_slave.sv
// APB completer in front of a single-ported, word-organised memory.
// Supports programmable wait states, byte-strobed writes and error
// responses for out-of-range or misaligned accesses.
module apb_mem_slave #(
  // Memory depth in 32-bit words; power of two, at least 2.
  parameter int unsigned DEPTH_WORDS = 1024,
  // Byte address of word 0; aligned to 4*DEPTH_WORDS.
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  // Access-phase cycles with pready low before completion (0..15).
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;

  // StArmed means a setup edge has been seen for the transfer in flight.
  typedef enum logic [0:0] {StIdle, StArmed} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [31:0]    prdata_q, prdata_d;

  logic [31:0]    mem [DEPTH_WORDS];

  logic           setup_phase;
  logic           access_phase;
  logic [31:0]    offset;
  logic [AW-1:0]  addr_idx;
  logic           addr_err;
  logic [31:0]    rd_word;
  logic           xfer_err;
  logic           ready;
  logic           wr_en;
  logic           unused_offset;

  assign setup_phase  = psel & ~penable;
  assign access_phase = psel & penable;

  // Address decode for the setup edge.
  assign offset   = paddr - BASE_ADDR;
  assign addr_idx = offset[AW+1:2];
  assign addr_err = (paddr < BASE_ADDR) | ({1'b0, offset} >= SPAN) | (paddr[1:0] != 2'b00);
  assign rd_word  = mem[addr_idx];

  assign unused_offset = ^{offset[31:AW+2], offset[1:0]};

  // An access phase without a preceding setup edge is always an error.
  assign xfer_err = (state_q == StArmed) ? err_q : 1'b1;
  // Reset forces pready low at once, so a reset-interrupted write never commits.
  assign ready    = access_phase & (cnt_q == WAIT_CNT) & ~rst;
  assign wr_en    = ready & pwrite & ~xfer_err;

  assign pready  = ready;
  assign pslverr = ready & xfer_err;
  assign prdata  = prdata_q;

  // Next-state: setup captures decode/read data, access counts wait cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    idx_d    = idx_q;
    prdata_d = prdata_q;
    if (setup_phase) begin
      state_d = StArmed;
      cnt_d   = 4'd0;
      err_d   = addr_err;
      idx_d   = addr_idx;
      if (!pwrite) begin
        prdata_d = addr_err ? 32'd0 : rd_word;
      end
    end else if (access_phase) begin
      if (ready) begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end else if (cnt_q != WAIT_CNT) begin
        cnt_d = cnt_q + 4'd1;
      end
    end else begin
      // Idle, or psel dropped mid-transfer: abort and rearm.
      state_d = StIdle;
      cnt_d   = 4'd0;
    end
  end

  // Control and read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      prdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
      prdata_q <= prdata_d;
    end
  end

  // Memory array is never reset; byte-strobed write on the completion edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (pstrb[b]) begin
          mem[idx_q][8*b +: 8] <= pwdata[8*b +: 8];
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) pslverr |-> pready);
  assert property (@(posedge clk) disable iff (rst) cnt_q <= WAIT_CNT);

endmodule
